mem_stage_ctrl: RTL

Memory-stage access controller between the pipeline's M stage and a variable-latency, word-wide data bus. It converts byte, halfword and word loads and stores into byte-enabled bus transactions, returns sign- or zero-extended load data as `readdataM`, and raises `stallM` to the hazard unit until the transaction completes. It sits directly downstream of the datapath's `aluoutM`/`writedataM` registers and in place of a combinational data memory.

---
 rtl/mem_pkg.sv | 38 +++
 rtl/mem_stage_ctrl_if.sv | 21 ++
 rtl/load_align.sv | 26 ++
 rtl/mem_stage_ctrl.sv | 109 ++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and store-formatting helpers for the memory-stage controller.
// Pure declarations; no timing or flow control of its own.
package mem_pkg;

  typedef enum logic [1:0] {
    MS_BYTE = 2'b00,
    MS_HALF = 2'b01,
    MS_WORD = 2'b10
  } memsize_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } memstate_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Size 2'b11 is reserved and behaves as a word everywhere.
  function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      MS_BYTE: return BE_BYTE << lane;
      MS_HALF: return BE_HALF << lane;
      default: return BE_WORD;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      MS_BYTE: return {4{wd[7:0]}};
      MS_HALF: return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Word-wide data bus: request held until a one-cycle ack; rdata valid with ack.
// Master is the controller, slave is the memory or interconnect.
interface mem_stage_ctrl_if #(parameter int AW = 32);
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [3:0]    bus_be;
  logic [31:0]   bus_wdata;
  logic          bus_ack;
  logic [31:0]   bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/load_align.sv
// Lane select plus sign/zero extension of a little-endian bus word.
// Purely combinational; no flow control.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[8*i_lane +: 8];
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      MS_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      MS_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// M-stage load/store to variable-latency bus; 3+ cycles in M (2 stall + 1 per wait).
// Stalls the pipeline from access entry until the cycle after bus_ack.
module mem_stage_ctrl
  import mem_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [1:0]  memsizeM,
  input  logic        memunsignedM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        misalignM,
  mem_stage_ctrl_if.master bus
);

  memstate_t     r_state, w_next;
  logic          r_req, r_we;
  logic [AW-1:0] r_addr;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata, r_rdata;
  logic [1:0]    r_size, r_lane;
  logic          r_uns;

  logic          w_access, w_misalign, w_stall, w_start;
  logic [31:0]   w_load;

  assign w_access   = memreadM | memwriteM;
  assign w_misalign = w_access &
                      (((memsizeM == MS_HALF) & aluoutM[0]) |
                       ((memsizeM[1] == 1'b1) & (aluoutM[1:0] != 2'b00)));

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access && !w_misalign) begin
          w_stall = 1'b1;
          w_start = 1'b1;
          w_next  = REQ;
        end
      end
      REQ: begin
        w_stall = 1'b1;
        if (bus.bus_ack) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  load_align u_load_align (
    .i_rdata    (bus.bus_rdata),
    .i_lane     (r_lane),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .o_data     (w_load)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= 4'b0000;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_size  <= 2'b00;
      r_lane  <= 2'b00;
      r_uns   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_req   <= 1'b1;
        r_we    <= memwriteM;
        r_addr  <= {aluoutM[AW-1:2], 2'b00};
        r_be    <= store_be(memsizeM, aluoutM[1:0]);
        r_wdata <= store_wdata(memsizeM, writedataM);
        r_size  <= memsizeM;
        r_lane  <= aluoutM[1:0];
        r_uns   <= memunsignedM;
      end
      if (r_state == REQ && bus.bus_ack) begin
        r_req <= 1'b0;
        if (!r_we) r_rdata <= w_load;
      end
    end
  end

  // Outputs are forced quiet while reset is held so the hazard unit never sees a stray stall.
  assign stallM    = ~reset & w_stall;
  assign misalignM = ~reset & (r_state == IDLE) & w_misalign;
  assign readdataM = (misalignM || (memreadM && memwriteM)) ? 32'h0 : r_rdata;

  assign bus.bus_req   = r_req;
  assign bus.bus_we    = r_we;
  assign bus.bus_addr  = r_addr;
  assign bus.bus_be    = r_be;
  assign bus.bus_wdata = r_wdata;

endmodule
